// File: rtl/cra_pkg.sv
// rtl/cra_pkg.sv - shared defaults and stage-count helper for the pipelined ripple adder
package cra_pkg;

  localparam int CRA_DEF_N = 16;
  localparam int CRA_DEF_M = 8;

  function automatic int cra_stages(input int n, input int m);
    return n / m;
  endfunction

endpackage

// File: rtl/cra_seg.sv
// rtl/cra_seg.sv - combinational m-bit carry-ripple segment
module cra_seg
  import cra_pkg::*;
#(
  parameter int m = CRA_DEF_M
) (
  input  logic         cin,
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  output logic [m-1:0] s,
  output logic         cout
);

  always_comb begin : ripple
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < m; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/cra_pipe.sv
// rtl/cra_pipe.sv - pipelined carry-ripple adder, one register stage per m-bit segment
// Optional signed-overflow output enabled by defining CRA_PIPE_OVF_EN.
module cra_pipe
  import cra_pkg::*;
#(
  parameter int n = CRA_DEF_N,
  parameter int m = CRA_DEF_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] s,
`ifdef CRA_PIPE_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);

  localparam int S = cra_stages(n, m);

  if (n % m != 0) begin : g_bad_cfg
    $error("cra_pipe: n (%0d) must be a multiple of m (%0d)", n, m);
  end

  // Stall is global: every stage moves together or holds together.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < S; k++) begin : g_stg
    logic [m-1:0]       seg_a;
    logic [m-1:0]       seg_b;
    logic [m-1:0]       seg_s;
    logic               seg_ci;
    logic               seg_co;
    logic               v_in;
    logic               v_d;
    logic               v_q;
    logic               c_d;
    logic               c_q;
    logic [m*(k+1)-1:0] sum_in;
    logic [m*(k+1)-1:0] sum_d;
    logic [m*(k+1)-1:0] sum_q;

    if (k == 0) begin : g_src
      assign seg_a  = a[m-1:0];
      assign seg_b  = b[m-1:0];
      assign seg_ci = cin;
      assign v_in   = in_valid;
      assign sum_in = seg_s;
    end else begin : g_src
      assign seg_a  = g_stg[k-1].g_op.opa_q[m-1:0];
      assign seg_b  = g_stg[k-1].g_op.opb_q[m-1:0];
      assign seg_ci = g_stg[k-1].c_q;
      assign v_in   = g_stg[k-1].v_q;
      assign sum_in = {seg_s, g_stg[k-1].sum_q};
    end

    cra_seg #(.m(m)) u_seg (
      .cin  (seg_ci),
      .a    (seg_a),
      .b    (seg_b),
      .s    (seg_s),
      .cout (seg_co)
    );

    always_comb begin
      v_d   = v_q;
      c_d   = c_q;
      sum_d = sum_q;
      if (adv) begin
        v_d   = v_in;
        c_d   = seg_co;
        sum_d = sum_in;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        v_q   <= v_d;
        c_q   <= c_d;
        sum_q <= sum_d;
      end
    end

    // Skew registers keep only the operand segments not yet consumed.
    if (k < S - 1) begin : g_op
      localparam int W = n - m * (k + 1);
      logic [W-1:0] opa_in;
      logic [W-1:0] opb_in;
      logic [W-1:0] opa_d;
      logic [W-1:0] opa_q;
      logic [W-1:0] opb_d;
      logic [W-1:0] opb_q;

      if (k == 0) begin : g_osrc
        assign opa_in = a[n-1:m];
        assign opb_in = b[n-1:m];
      end else begin : g_osrc
        assign opa_in = g_stg[k-1].g_op.opa_q[W+m-1:m];
        assign opb_in = g_stg[k-1].g_op.opb_q[W+m-1:m];
      end

      always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        if (adv) begin
          opa_d = opa_in;
          opb_d = opb_in;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end

`ifdef CRA_PIPE_OVF_EN
    logic sa_in;
    logic sb_in;

    if (k == 0) begin : g_ssrc
      assign sa_in = a[n-1];
      assign sb_in = b[n-1];
    end else begin : g_ssrc
      assign sa_in = g_stg[k-1].g_sgn.sa_q;
      assign sb_in = g_stg[k-1].g_sgn.sb_q;
    end

    if (k < S - 1) begin : g_sgn
      logic sa_d;
      logic sa_q;
      logic sb_d;
      logic sb_q;

      always_comb begin
        sa_d = sa_q;
        sb_d = sb_q;
        if (adv) begin
          sa_d = sa_in;
          sb_d = sb_in;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sa_q <= 1'b0;
          sb_q <= 1'b0;
        end else begin
          sa_q <= sa_d;
          sb_q <= sb_d;
        end
      end
    end else begin : g_ovf
      // The top segment's MSB is the result sign, so overflow resolves here.
      logic ovf_d;
      logic ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
          ovf_d = (sa_in == sb_in) & (seg_s[m-1] != sa_in);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_valid = g_stg[S-1].v_q;
  assign s         = g_stg[S-1].sum_q;
  assign cout      = g_stg[S-1].c_q;
`ifdef CRA_PIPE_OVF_EN
  assign ovf       = g_stg[S-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_cra_pipe.sv
// tb/tb_cra_pipe.sv - directed self-checking bench for cra_pipe (16/8 and 8/8 builds)
module tb_cra_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] s;
  logic        cout;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic [7:0]  s8;
  logic        cout8;
`ifdef CRA_PIPE_OVF_EN
  logic        ovf;
  logic        ovf8;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vc [8];
  logic [16:0] exp_r [8];

  always #5 clk = ~clk;

  cra_pipe #(.n(16), .m(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
`ifdef CRA_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  cra_pipe #(.n(8), .m(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .cin       (cin),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .s         (s8),
`ifdef CRA_PIPE_OVF_EN
    .ovf       (ovf8),
`endif
    .cout      (cout8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input string tag, input int stall_at);
    int          sent;
    int          got;
    int          first_cyc;
    int          last_cyc;
    logic [15:0] held_s;
    logic        held_c;
    sent = 0;
    got = 0;
    first_cyc = -1;
    last_cyc = -1;
    held_s = '0;
    held_c = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a   = va[sent];
        b   = vb[sent];
        cin = vc[sent];
      end
      #1;
      if (!out_ready) begin
        chk({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
        if (cyc > stall_at) begin
          chk({tag, " stall s frozen"}, 32'(s), 32'(held_s));
          chk({tag, " stall cout frozen"}, 32'(cout), 32'(held_c));
        end
        held_s = s;
        held_c = cout;
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        chk({tag, " s"}, 32'(s), 32'(exp_r[got][15:0]));
        chk({tag, " cout"}, 32'(cout), 32'(exp_r[got][16]));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, " result count"}, 32'(got), 32'd8);
    chk({tag, " first out cycle"}, 32'(first_cyc), 32'd2);
    chk({tag, " last out cycle"}, 32'(last_cyc), (stall_at >= 0) ? 32'd12 : 32'd9);
  endtask

  initial begin
    va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 1'b1;
    va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b0;
    va[3] = 16'h00FF; vb[3] = 16'hFF01; vc[3] = 1'b0;
    va[4] = 16'hABCD; vb[4] = 16'h5432; vc[4] = 1'b1;
    va[5] = 16'h0F0F; vb[5] = 16'hF0F0; vc[5] = 1'b1;
    va[6] = 16'h7FFF; vb[6] = 16'h0001; vc[6] = 1'b0;
    va[7] = 16'hCAFE; vb[7] = 16'hBABE; vc[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_r[i] = {1'b0, va[i]} + {1'b0, vb[i]} + 17'(vc[i]);
    end

    rst = 1'b1;
    tick();
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset s", 32'(s), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid8", 32'(out_valid8), 32'd0);
`ifdef CRA_PIPE_OVF_EN
    chk("reset ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat1 out_valid early", 32'(out_valid), 32'd0);
    tick();
    chk("lat1 out_valid", 32'(out_valid), 32'd1);
    chk("lat1 s", 32'(s), 32'h0100);
    chk("lat1 cout", 32'(cout), 32'd0);
    tick();
    chk("lat1 out_valid drop", 32'(out_valid), 32'd0);

    a = 16'hFFFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("carry out_valid", 32'(out_valid), 32'd1);
    chk("carry s", 32'(s), 32'h0000);
    chk("carry cout", 32'(cout), 32'd1);
    tick();

    run_stream("stream", -10);
    run_stream("stall", 4);

    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst s", 32'(s), 32'd0);
    chk("midrst cout", 32'(cout), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst no leak", 32'(out_valid), 32'd0);
    a = 16'h00F0; b = 16'h0F10; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("postrst out_valid", 32'(out_valid), 32'd1);
    chk("postrst s", 32'(s), 32'h1001);
    chk("postrst cout", 32'(cout), 32'd0);
    tick();

    a8 = 8'hFF; b8 = 8'h01; cin = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    chk("s1 out_valid", 32'(out_valid8), 32'd1);
    chk("s1 s", 32'(s8), 32'h00);
    chk("s1 cout", 32'(cout8), 32'd1);
    tick();
    chk("s1 out_valid drop", 32'(out_valid8), 32'd0);

`ifdef CRA_PIPE_OVF_EN
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'h0001;
    tick();
    in_valid = 1'b0;
    chk("ovf pos s", 32'(s), 32'h8000);
    chk("ovf pos ovf", 32'(ovf), 32'd1);
    chk("ovf pos cout", 32'(cout), 32'd0);
    tick();
    chk("ovf neg s", 32'(s), 32'h0000);
    chk("ovf neg ovf", 32'(ovf), 32'd0);
    chk("ovf neg cout", 32'(cout), 32'd1);
    tick();
    a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    chk("s1 ovf", 32'(ovf8), 32'd1);
    chk("s1 ovf s", 32'(s8), 32'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
